// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT = 4;
  localparam int unsigned WAIT_CNT_W       = 8;

  typedef enum logic [1:0] {
    ARB_PIPE = 2'd0,
    ARB_AUX  = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating starvation counter; atMax_o rises once the count has sat at MAX_WAIT
// for a full waiting cycle, so the forced grant lands MAX_WAIT+1 cycles after the wait starts.
module dmem_arb_wait_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic atMax_o
);

  localparam logic [WAIT_CNT_W-1:0] MaxCnt = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] cntQ;
  logic                  atMaxQ;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cntQ   <= '0;
      atMaxQ <= 1'b0;
    end else if (clr_i) begin
      cntQ   <= '0;
      atMaxQ <= 1'b0;
    end else if (inc_i) begin
      if (cntQ == MaxCnt) atMaxQ <= 1'b1;
      else                cntQ   <= cntQ + WAIT_CNT_W'(1);
    end
  end

  assign atMax_o = atMaxQ;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter between the pipeline MEM stage and an auxiliary requester for the data memory.
// Optional performance counters are enabled with DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          pipe_re_i,
  input  logic          pipe_we_i,
  input  logic [AW-1:0] pipe_addr_i,
  input  logic [DW-1:0] pipe_wdata_i,
  output logic [DW-1:0] pipe_rdata_o,
  output logic          stall_o,
  input  logic          aux_req_i,
  input  logic          aux_we_i,
  input  logic [AW-1:0] aux_addr_i,
  input  logic [DW-1:0] aux_wdata_i,
  output logic          aux_gnt_o,
  output logic          aux_rvalid_o,
  output logic [DW-1:0] aux_rdata_o,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]   perf_stall_cnt_o,
  output logic [31:0]   perf_aux_gnt_cnt_o,
`endif
  output logic          mem_re_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  arb_state_e stateQ, stateD;
  logic       pipeBusy, auxGnt, forced, atMax, forcedRdQ;

  assign pipeBusy = pipe_re_i | pipe_we_i;
  // Gated by reset so the memory sees no enables while reset is held.
  assign auxGnt   = reset_ni & aux_req_i &
                    (!pipeBusy | (atMax & (stateQ != ARB_HOLD)));
  assign forced   = auxGnt & pipeBusy;

  assign aux_gnt_o    = auxGnt;
  assign stall_o      = forced;
  assign pipe_rdata_o = mem_rdata_i;

  assign mem_re_o    = reset_ni & (auxGnt ? !aux_we_i : pipe_re_i);
  assign mem_we_o    = reset_ni & (auxGnt ?  aux_we_i : pipe_we_i);
  assign mem_addr_o  = auxGnt ? aux_addr_i  : pipe_addr_i;
  assign mem_wdata_o = auxGnt ? aux_wdata_i : pipe_wdata_i;

  dmem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clr_i   (auxGnt | !aux_req_i),
    .inc_i   (aux_req_i & pipeBusy & !auxGnt),
    .atMax_o (atMax)
  );

  // Next state; a forced read keeps aux off the port one extra cycle via ARB_HOLD.
  always_comb begin
    stateD = ARB_PIPE;
    if (auxGnt && !aux_we_i)  stateD = ARB_AUX;
    else if (forced)          stateD = ARB_HOLD;
    else if (auxGnt)          stateD = ARB_PIPE;
    else if (stateQ == ARB_AUX && forcedRdQ && aux_req_i && pipeBusy)
                              stateD = ARB_HOLD;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stateQ       <= ARB_PIPE;
      forcedRdQ    <= 1'b0;
      aux_rvalid_o <= 1'b0;
      aux_rdata_o  <= '0;
    end else begin
      stateQ       <= stateD;
      forcedRdQ    <= forced & !aux_we_i;
      aux_rvalid_o <= auxGnt & !aux_we_i;
      if (auxGnt && !aux_we_i) aux_rdata_o <= mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perfStallQ, perfGntQ;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perfStallQ <= '0;
      perfGntQ   <= '0;
    end else begin
      if (forced) perfStallQ <= perfStallQ + 32'd1;
      if (auxGnt) perfGntQ   <= perfGntQ + 32'd1;
    end
  end

  assign perf_stall_cnt_o   = perfStallQ;
  assign perf_aux_gnt_cnt_o = perfGntQ;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_WAIT = 4).
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          pipe_re_i, pipe_we_i;
  logic [AW-1:0] pipe_addr_i;
  logic [DW-1:0] pipe_wdata_i, pipe_rdata_o;
  logic          stall_o;
  logic          aux_req_i, aux_we_i;
  logic [AW-1:0] aux_addr_i;
  logic [DW-1:0] aux_wdata_i;
  logic          aux_gnt_o, aux_rvalid_o;
  logic [DW-1:0] aux_rdata_o;
  logic          mem_re_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_stall_cnt_o, perf_aux_gnt_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.MAX_WAIT(4), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .pipe_re_i   (pipe_re_i),
    .pipe_we_i   (pipe_we_i),
    .pipe_addr_i (pipe_addr_i),
    .pipe_wdata_i(pipe_wdata_i),
    .pipe_rdata_o(pipe_rdata_o),
    .stall_o     (stall_o),
    .aux_req_i   (aux_req_i),
    .aux_we_i    (aux_we_i),
    .aux_addr_i  (aux_addr_i),
    .aux_wdata_i (aux_wdata_i),
    .aux_gnt_o   (aux_gnt_o),
    .aux_rvalid_o(aux_rvalid_o),
    .aux_rdata_o (aux_rdata_o),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cnt_o  (perf_stall_cnt_o),
    .perf_aux_gnt_cnt_o(perf_aux_gnt_cnt_o),
`endif
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_re_i = 1'b0; pipe_we_i = 1'b0; pipe_addr_i = '0; pipe_wdata_i = '0;
    aux_req_i = 1'b0; aux_we_i = 1'b0; aux_addr_i = '0; aux_wdata_i = '0;
    mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    reset_ni     = 1'b0;
    pipe_re_i    = 1'b1;
    pipe_we_i    = 1'($urandom_range(0, 1));
    pipe_addr_i  = 32'h0000_0ABC;
    pipe_wdata_i = $urandom;
    aux_req_i    = 1'b1;
    aux_we_i     = 1'($urandom_range(0, 1));
    aux_addr_i   = $urandom;
    aux_wdata_i  = $urandom;
    mem_rdata_i  = $urandom;
    repeat (3) next_cycle();
    @(negedge clk_i);
    checks++;
    if ({stall_o, aux_gnt_o, aux_rvalid_o, mem_we_o, mem_re_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got stall/gnt/rvalid/we/re=%b want 00000",
               {stall_o, aux_gnt_o, aux_rvalid_o, mem_we_o, mem_re_o});
    end
    checks++;
    if (aux_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got %h want 00000000", aux_rdata_o);
    end
    checks++;
    if (mem_addr_o !== 32'h0000_0ABC) begin
      failures++;
      $display("FAIL reset_addr got %h want 00000abc", mem_addr_o);
    end
    next_cycle();
    idle_inputs();
    reset_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_aux_read();
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h40; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    checks++;
    if ({aux_gnt_o, mem_re_o, mem_we_o, stall_o} !== 4'b1100 || mem_addr_o !== 32'h40) begin
      failures++;
      $display("FAIL aux_read_issue got gnt/re/we/stall=%b addr=%h want 1100 addr=00000040",
               {aux_gnt_o, mem_re_o, mem_we_o, stall_o}, mem_addr_o);
    end
    checks++;
    if (pipe_rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL pipe_rdata got %h want deadbeef", pipe_rdata_o);
    end
    next_cycle();
    aux_req_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk_i);
    checks++;
    if (aux_rvalid_o !== 1'b1 || aux_rdata_o !== 32'hDEADBEEF || aux_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL aux_read_resp got rvalid=%b rdata=%h gnt=%b want 1 deadbeef 0",
               aux_rvalid_o, aux_rdata_o, aux_gnt_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (aux_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL aux_read_one_shot got rvalid=%b want 0", aux_rvalid_o);
    end
    next_cycle();
  endtask

  // Forced write at cycle 5, ARB_HOLD at cycle 6, next forced grant at cycle 11.
  task automatic test_starvation();
    logic exp;
    pipe_re_i = 1'b1; pipe_addr_i = 32'h100;
    aux_req_i = 1'b1; aux_we_i = 1'b1; aux_addr_i = 32'h200; aux_wdata_i = 32'h0000A5A5;
    for (int c = 0; c <= 12; c++) begin
      exp = (c == 5) || (c == 11);
      @(negedge clk_i);
      checks++;
      if (aux_gnt_o !== exp || stall_o !== exp) begin
        failures++;
        $display("FAIL starve_gnt cycle %0d got gnt=%b stall=%b want %b", c, aux_gnt_o, stall_o, exp);
      end
      checks++;
      if (mem_addr_o !== (exp ? 32'h200 : 32'h100) || mem_we_o !== exp || mem_re_o !== !exp) begin
        failures++;
        $display("FAIL starve_mem cycle %0d got addr=%h we=%b re=%b", c, mem_addr_o, mem_we_o, mem_re_o);
      end
`ifdef DMEM_ARB_PERF_EN
      if (c == 6) begin
        checks++;
        if (perf_stall_cnt_o !== 32'd1 || perf_aux_gnt_cnt_o !== 32'd2) begin
          failures++;
          $display("FAIL perf_cnt got stall=%0d gnt=%0d want 1 2", perf_stall_cnt_o, perf_aux_gnt_cnt_o);
        end
      end
`endif
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  // Forced read: response on the next cycle, then ARB_HOLD, next force at cycle 11.
  task automatic test_forced_read();
    logic exp;
    pipe_we_i = 1'b1; pipe_addr_i = 32'h300;
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h400;
    for (int c = 0; c <= 12; c++) begin
      mem_rdata_i = 32'hCAFE0000 + 32'(c);
      exp = (c == 5) || (c == 11);
      @(negedge clk_i);
      checks++;
      if (aux_gnt_o !== exp || stall_o !== exp || mem_re_o !== exp) begin
        failures++;
        $display("FAIL fread_gnt cycle %0d got gnt=%b stall=%b re=%b want %b",
                 c, aux_gnt_o, stall_o, mem_re_o, exp);
      end
      if (c == 6) begin
        checks++;
        if (aux_rvalid_o !== 1'b1 || aux_rdata_o !== 32'hCAFE0005) begin
          failures++;
          $display("FAIL fread_resp got rvalid=%b rdata=%h want 1 cafe0005", aux_rvalid_o, aux_rdata_o);
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_aux_write();
    aux_req_i = 1'b1; aux_we_i = 1'b1; aux_wdata_i = 32'h12345678; aux_addr_i = 32'h80;
    @(negedge clk_i);
    checks++;
    if ({aux_gnt_o, mem_we_o, mem_re_o, stall_o} !== 4'b1100 ||
        mem_wdata_o !== 32'h12345678 || mem_addr_o !== 32'h80) begin
      failures++;
      $display("FAIL aux_write got gnt/we/re/stall=%b wdata=%h addr=%h",
               {aux_gnt_o, mem_we_o, mem_re_o, stall_o}, mem_wdata_o, mem_addr_o);
    end
    next_cycle();
    aux_req_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      checks++;
      if (aux_rvalid_o !== 1'b0 || mem_we_o !== 1'b0) begin
        failures++;
        $display("FAIL aux_write_after cycle %0d got rvalid=%b we=%b want 0 0", c, aux_rvalid_o, mem_we_o);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h10; mem_rdata_i = 32'h11;
    @(negedge clk_i);
    checks++;
    if (aux_gnt_o !== 1'b1 || mem_addr_o !== 32'h10) begin
      failures++;
      $display("FAIL b2b_first got gnt=%b addr=%h want 1 00000010", aux_gnt_o, mem_addr_o);
    end
    next_cycle();
    aux_addr_i = 32'h14; mem_rdata_i = 32'h22;
    @(negedge clk_i);
    checks++;
    if (aux_gnt_o !== 1'b1 || mem_addr_o !== 32'h14 || aux_rvalid_o !== 1'b1 || aux_rdata_o !== 32'h11) begin
      failures++;
      $display("FAIL b2b_second got gnt=%b addr=%h rvalid=%b rdata=%h", aux_gnt_o, mem_addr_o, aux_rvalid_o, aux_rdata_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (aux_rvalid_o !== 1'b1 || aux_rdata_o !== 32'h22) begin
      failures++;
      $display("FAIL b2b_resp got rvalid=%b rdata=%h want 1 00000022", aux_rvalid_o, aux_rdata_o);
    end
    next_cycle();
  endtask

  task automatic test_pipe_pass();
    pipe_re_i = 1'b1; pipe_we_i = 1'b1; pipe_addr_i = 32'h55; pipe_wdata_i = 32'h66;
    @(negedge clk_i);
    checks++;
    if (mem_re_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h55 ||
        mem_wdata_o !== 32'h66 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL pipe_pass got re=%b we=%b addr=%h wdata=%h stall=%b",
               mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h20; mem_rdata_i = 32'h77;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (aux_rvalid_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_rvalid_pre got %b want 1", aux_rvalid_o);
    end
    reset_ni = 1'b0;
    #1;
    checks++;
    if (aux_rvalid_o !== 1'b0 || aux_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_async got rvalid=%b rdata=%h want 0 00000000", aux_rvalid_o, aux_rdata_o);
    end
    next_cycle();
    reset_ni = 1'b1;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    reset_ni = 1'b0;
    test_reset();
    test_aux_read();
    test_starvation();
    test_forced_read();
    test_aux_write();
    test_back_to_back();
    test_pipe_pass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
